memory_read_split: RTL and testbench

// - Parametrised read splitter/merger between the execute-side read port and the TLB read port.
// - Turns one read of up to DATA_BYTES bytes into one TLB access, or into two when it crosses a

---
 rtl/memory_read_split.sv | 204 ++++++++++++++++++++
 tb/tb_memory_read_split.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_split.sv
// rtl/memory_read_split.sv - read splitter/merger between execute read port and TLB read port
//
// Purpose: turns one execute-side read of up to DATA_BYTES bytes into one TLB access,
// or into two when the read crosses a LINE_BYTES boundary (SPLIT_EN=1). The two halves
// are merged little-endian into read_data. Page/alignment faults are sticky until
// rd_reset; rd_reset while busy drains the outstanding TLB access silently.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   rd_reset               pipeline abort/clear pulse
//   read_do / read_done    execute request (held) / one-cycle completion pulse
//   read_page_fault        sticky page fault
//   read_ac_fault          sticky alignment-check fault
//   read_cpl/lock/rmw      attributes forwarded to tlbread_cpl/lock/rmw
//   read_address/length    linear byte address, length 1..DATA_BYTES
//   read_data              merged data, bytes at or above read_length are zero
//   tlbread_do             TLB request, held until done/fault/retry
//   tlbread_done/..._fault/tlbread_retry  TLB status
//   tlbread_address/length current access; tlbread_length_full = read_length
//   tlbread_data           TLB data, byte 0 = byte at tlbread_address
module memory_read_split #(
  parameter int LINE_BYTES = 16,
  parameter int DATA_BYTES = 8,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_reset,
  input  logic                    read_do,
  output logic                    read_done,
  output logic                    read_page_fault,
  output logic                    read_ac_fault,
  input  logic [1:0]              read_cpl,
  input  logic [31:0]             read_address,
  input  logic [3:0]              read_length,
  input  logic                    read_lock,
  input  logic                    read_rmw,
  output logic [8*DATA_BYTES-1:0] read_data,
  output logic                    tlbread_do,
  input  logic                    tlbread_done,
  input  logic                    tlbread_page_fault,
  input  logic                    tlbread_ac_fault,
  input  logic                    tlbread_retry,
  output logic [1:0]              tlbread_cpl,
  output logic                    tlbread_lock,
  output logic                    tlbread_rmw,
  output logic [31:0]             tlbread_address,
  output logic [3:0]              tlbread_length,
  output logic [3:0]              tlbread_length_full,
  input  logic [8*DATA_BYTES-1:0] tlbread_data
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int HI_W  = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t                  state, state_next;
  logic                    reset_waiting, reset_waiting_next;
  logic [31:0]             addr_q;
  logic [4:0]              l1_q, l2_q;
  logic [8*DATA_BYTES-1:0] first_buf;
  logic [8*DATA_BYTES-1:0] merged;

  logic [OFF_W-1:0]        off;
  logic [7:0]              room;
  logic [4:0]              len5, l1_calc, l2_calc;
  logic [31:0]             next_line;
  logic                    start, abort, tlb_end;
  logic                    complete, buffer_first, set_pf, set_af;

  assign tlbread_cpl         = read_cpl;
  assign tlbread_lock        = read_lock;
  assign tlbread_rmw         = read_rmw;
  assign tlbread_length_full = read_length;

  // Bytes left in the current line; 8 bits so LINE_BYTES=64 with off=0 does not wrap.
  assign off  = read_address[OFF_W-1:0];
  assign room = 8'(LINE_BYTES) - 8'(off);
  assign len5 = {1'b0, read_length};

  always_comb begin
    l1_calc = len5;
    if (SPLIT_EN && ({3'b000, len5} > room)) begin
      l1_calc = room[4:0];
    end
    l2_calc = len5 - l1_calc;
  end

  // Second access starts at the following line base; the address wraps modulo 2^32.
  assign next_line = {addr_q[31:OFF_W] + HI_W'(1), {OFF_W{1'b0}}};

  assign start   = rst_n && (state == IDLE) && read_do && !read_done && !rd_reset &&
                   !read_page_fault && !read_ac_fault;
  assign abort   = rd_reset || reset_waiting;
  assign tlb_end = tlbread_done || tlbread_page_fault || tlbread_ac_fault || tlbread_retry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      reset_waiting <= 1'b0;
    end else begin
      state         <= state_next;
      reset_waiting <= reset_waiting_next;
    end
  end

  always_comb begin
    state_next         = state;
    reset_waiting_next = reset_waiting;
    complete           = 1'b0;
    buffer_first       = 1'b0;
    set_pf             = 1'b0;
    set_af             = 1'b0;
    tlbread_do         = 1'b0;
    tlbread_address    = read_address;
    tlbread_length     = l1_calc[3:0];
    case (state)
      IDLE: begin
        reset_waiting_next = 1'b0;
        if (start) begin
          tlbread_do = 1'b1;
          state_next = FIRST;
        end
      end
      FIRST, SECOND: begin
        tlbread_do      = 1'b1;
        tlbread_address = (state == FIRST) ? addr_q : next_line;
        tlbread_length  = (state == FIRST) ? l1_q[3:0] : l2_q[3:0];
        if (abort) begin
          // Draining: any TLB status ends the access, nothing is reported.
          if (tlb_end) begin
            state_next         = IDLE;
            reset_waiting_next = 1'b0;
          end else begin
            reset_waiting_next = 1'b1;
          end
        end else if (tlbread_page_fault || tlbread_ac_fault) begin
          set_pf     = tlbread_page_fault;
          set_af     = tlbread_ac_fault;
          state_next = IDLE;
        end else if (tlbread_retry) begin
          state_next = state;
        end else if (tlbread_done) begin
          if ((state == FIRST) && (l2_q != 5'd0)) begin
            buffer_first = 1'b1;
            state_next   = SECOND;
          end else begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Merge: low L1 bytes come from the first access (buffered if split), the next L2
  // bytes from the current TLB data, everything above read_length is zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(l1_q)) begin
        merged[8*i +: 8] = (state == SECOND) ? first_buf[8*i +: 8] : tlbread_data[8*i +: 8];
      end else if (i < int'(l1_q) + int'(l2_q)) begin
        merged[8*i +: 8] = tlbread_data[8*(i - int'(l1_q)) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_done       <= 1'b0;
      read_page_fault <= 1'b0;
      read_ac_fault   <= 1'b0;
      read_data       <= '0;
      addr_q          <= '0;
      l1_q            <= '0;
      l2_q            <= '0;
      first_buf       <= '0;
    end else begin
      read_done <= complete;
      if (start) begin
        addr_q <= read_address;
        l1_q   <= l1_calc;
        l2_q   <= l2_calc;
      end
      if (buffer_first) begin
        first_buf <= tlbread_data;
      end
      if (complete) begin
        read_data <= merged;
      end
      if (rd_reset) begin
        read_page_fault <= 1'b0;
        read_ac_fault   <= 1'b0;
      end else begin
        if (set_pf) read_page_fault <= 1'b1;
        if (set_af) read_ac_fault   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_read_split.sv
// tb/tb_memory_read_split.sv - self-checking bench for memory_read_split
module tb_memory_read_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_rd_reset, resp_rd_reset, rd_reset, read_do;
  logic        read_done, read_page_fault, read_ac_fault;
  logic [1:0]  read_cpl;
  logic [31:0] read_address;
  logic [3:0]  read_length;
  logic        read_lock, read_rmw;
  logic [63:0] read_data;
  logic        tlbread_do, tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry;
  logic [1:0]  tlbread_cpl;
  logic        tlbread_lock, tlbread_rmw;
  logic [31:0] tlbread_address;
  logic [3:0]  tlbread_length, tlbread_length_full;
  logic [63:0] tlbread_data;

  assign rd_reset = req_rd_reset | resp_rd_reset;

  memory_read_split #(.LINE_BYTES(16), .DATA_BYTES(8), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset), .read_do(read_do),
    .read_done(read_done), .read_page_fault(read_page_fault), .read_ac_fault(read_ac_fault),
    .read_cpl(read_cpl), .read_address(read_address), .read_length(read_length),
    .read_lock(read_lock), .read_rmw(read_rmw), .read_data(read_data),
    .tlbread_do(tlbread_do), .tlbread_done(tlbread_done),
    .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
    .tlbread_retry(tlbread_retry), .tlbread_cpl(tlbread_cpl), .tlbread_lock(tlbread_lock),
    .tlbread_rmw(tlbread_rmw), .tlbread_address(tlbread_address),
    .tlbread_length(tlbread_length), .tlbread_length_full(tlbread_length_full),
    .tlbread_data(tlbread_data)
  );

  // Non-splitting instance, driven directly by one hand sequence.
  logic        ns_read_do, ns_read_done, ns_read_page_fault, ns_read_ac_fault;
  logic [31:0] ns_read_address, ns_tlbread_address;
  logic [3:0]  ns_read_length, ns_tlbread_length, ns_tlbread_length_full;
  logic [63:0] ns_read_data, ns_tlbread_data;
  logic        ns_tlbread_do, ns_tlbread_done, ns_tlbread_lock, ns_tlbread_rmw;
  logic [1:0]  ns_tlbread_cpl;

  memory_read_split #(.LINE_BYTES(16), .DATA_BYTES(8), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .rd_reset(1'b0), .read_do(ns_read_do),
    .read_done(ns_read_done), .read_page_fault(ns_read_page_fault),
    .read_ac_fault(ns_read_ac_fault), .read_cpl(2'd0), .read_address(ns_read_address),
    .read_length(ns_read_length), .read_lock(1'b0), .read_rmw(1'b0),
    .read_data(ns_read_data), .tlbread_do(ns_tlbread_do), .tlbread_done(ns_tlbread_done),
    .tlbread_page_fault(1'b0), .tlbread_ac_fault(1'b0), .tlbread_retry(1'b0),
    .tlbread_cpl(ns_tlbread_cpl), .tlbread_lock(ns_tlbread_lock), .tlbread_rmw(ns_tlbread_rmw),
    .tlbread_address(ns_tlbread_address), .tlbread_length(ns_tlbread_length),
    .tlbread_length_full(ns_tlbread_length_full), .tlbread_data(ns_tlbread_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    int          n_acc;
    logic [31:0] a0;
    logic [3:0]  l0;
    logic [31:0] a1;
    logic [3:0]  l1;
    logic [63:0] data;
  } vec_t;

  logic [7:0]  mem [256];
  logic [31:0] acc_addr [$];
  logic [3:0]  acc_len [$];
  int          cyc = 0, last_done_cyc = 0, done_seen_cyc = 0;
  int          n_vec = 0, n_err = 0;
  int          tlb_lat = 1, fault_idx = -1;
  bit          fault_ac = 0, tlb_retry = 0, retried = 0, reset_with_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // TLB responder: waits tlb_lat cycles after seeing a request, then returns memory bytes.
  initial begin : tlb_model
    int idx;
    tlbread_done = 0; tlbread_page_fault = 0; tlbread_ac_fault = 0; tlbread_retry = 0;
    tlbread_data = '0; resp_rd_reset = 0;
    forever begin
      @(negedge clk);
      if (tlbread_do) begin
        repeat (tlb_lat) @(negedge clk);
        if (tlb_retry && !retried) begin
          retried = 1; tlbread_retry = 1;
          @(negedge clk);
          tlbread_retry = 0;
          @(negedge clk);
        end
        idx = acc_addr.size();
        acc_addr.push_back(tlbread_address);
        acc_len.push_back(tlbread_length);
        last_done_cyc = cyc;
        for (int i = 0; i < 8; i++) tlbread_data[8*i +: 8] = mem[8'(tlbread_address + 32'(i))];
        if (idx == fault_idx) begin
          tlbread_page_fault = !fault_ac;
          tlbread_ac_fault   = fault_ac;
        end else begin
          tlbread_done = 1;
        end
        resp_rd_reset = reset_with_done;
        @(negedge clk);
        tlbread_done = 0; tlbread_page_fault = 0; tlbread_ac_fault = 0; resp_rd_reset = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] l, output bit got, output bit after);
    @(posedge clk); #1;
    read_address = a; read_length = l; read_do = 1;
    got = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (read_done) begin got = 1; done_seen_cyc = cyc; break; end
      if (read_page_fault || read_ac_fault) break;
    end
    @(posedge clk); #1 read_do = 0;
    @(negedge clk);
    after = read_done;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit got, after;
    acc_addr.delete(); acc_len.delete(); retried = 0;
    do_read(v.addr, v.len, got, after);
    check({tag, " done"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(done_seen_cyc), 64'(last_done_cyc + 1));
    check({tag, " pulse"}, 64'(after), 64'd0);
    check({tag, " data"}, read_data, v.data);
    check({tag, " n_acc"}, 64'(acc_addr.size()), 64'(v.n_acc));
    if (acc_addr.size() >= 1) begin
      check({tag, " a0"}, 64'(acc_addr[0]), 64'(v.a0));
      check({tag, " l0"}, 64'(acc_len[0]), 64'(v.l0));
    end
    if (v.n_acc == 2 && acc_addr.size() == 2) begin
      check({tag, " a1"}, 64'(acc_addr[1]), 64'(v.a1));
      check({tag, " l1"}, 64'(acc_len[1]), 64'(v.l1));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rd_reset();
    @(posedge clk); #1 req_rd_reset = 1;
    @(posedge clk); #1 req_rd_reset = 0;
    @(negedge clk);
  endtask

  vec_t        tbl [9];
  vec_t        v;
  bit          got, after, flag;
  logic [63:0] prev;
  int          off;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
    mem[8'h04] = 8'hAA; mem[8'h05] = 8'hBB; mem[8'h06] = 8'hCC; mem[8'h07] = 8'hDD;
    mem[8'h0E] = 8'h11; mem[8'h0F] = 8'h22; mem[8'h10] = 8'h33; mem[8'h11] = 8'h44;

    tbl[0] = '{32'h00001004, 4'd4, 1, 32'h00001004, 4'd4, 32'h0, 4'd0, 64'hDDCCBBAA};
    tbl[1] = '{32'h0000100E, 4'd4, 2, 32'h0000100E, 4'd2, 32'h00001010, 4'd2, 64'h44332211};
    tbl[2] = '{32'hFFFFFFFC, 4'd8, 2, 32'hFFFFFFFC, 4'd4, 32'h00000000, 4'd4, 64'h434241403F3E3D3C};
    tbl[3] = '{32'h00001008, 4'd8, 1, 32'h00001008, 4'd8, 32'h0, 4'd0, 64'h22114D4C4B4A4948};
    tbl[4] = '{32'h0000100F, 4'd1, 1, 32'h0000100F, 4'd1, 32'h0, 4'd0, 64'h22};
    tbl[5] = '{32'h0000100F, 4'd8, 2, 32'h0000100F, 4'd1, 32'h00001010, 4'd7, 64'h5655545352443322};
    tbl[6] = '{32'h00001000, 4'd2, 1, 32'h00001000, 4'd2, 32'h0, 4'd0, 64'h4140};
    tbl[7] = '{32'h0000100D, 4'd3, 1, 32'h0000100D, 4'd3, 32'h0, 4'd0, 64'h22114D};
    tbl[8] = '{32'h0000100D, 4'd4, 2, 32'h0000100D, 4'd3, 32'h00001010, 4'd1, 64'h3322114D};

    rst_n = 0; req_rd_reset = 0; read_do = 0; read_cpl = 2'd3; read_address = '0;
    read_length = 4'd1; read_lock = 0; read_rmw = 0;
    ns_read_do = 0; ns_read_address = '0; ns_read_length = 4'd1; ns_tlbread_done = 0;
    ns_tlbread_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset read_done", 64'(read_done), 64'd0);
    check("reset page_fault", 64'(read_page_fault), 64'd0);
    check("reset ac_fault", 64'(read_ac_fault), 64'd0);
    check("reset tlbread_do", 64'(tlbread_do), 64'd0);
    check("reset read_data", read_data, 64'd0);
    check("fwd cpl", 64'(tlbread_cpl), 64'd3);

    for (int i = 0; i < 9; i++) begin
      tlb_lat = 1 + (i % 3);
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Page fault on the second access: sticky, blocks new reads until rd_reset.
    tlb_lat = 1; fault_idx = 1; fault_ac = 0;
    acc_addr.delete(); acc_len.delete();
    do_read(32'h0000100E, 4'd4, got, after);
    fault_idx = -1;
    check("pf2 no done", 64'(got), 64'd0);
    check("pf2 flag", 64'(read_page_fault), 64'd1);
    check("pf2 ac clear", 64'(read_ac_fault), 64'd0);
    check("pf2 n_acc", 64'(acc_addr.size()), 64'd2);
    @(posedge clk); #1 read_do = 1;
    flag = 0;
    repeat (4) begin @(negedge clk); flag |= tlbread_do; end
    check("pf2 blocked", 64'(flag), 64'd0);
    check("pf2 sticky", 64'(read_page_fault), 64'd1);
    @(posedge clk); #1 read_do = 0;
    pulse_rd_reset();
    check("pf2 cleared", 64'(read_page_fault), 64'd0);
    run_vec(tbl[0], "after pf");

    // Alignment fault on the first half of a split read: second half never issued.
    fault_idx = 0; fault_ac = 1;
    acc_addr.delete(); acc_len.delete();
    do_read(32'h0000100E, 4'd4, got, after);
    fault_idx = -1; fault_ac = 0;
    repeat (3) @(negedge clk);
    check("ac1 no done", 64'(got), 64'd0);
    check("ac1 flag", 64'(read_ac_fault), 64'd1);
    check("ac1 pf clear", 64'(read_page_fault), 64'd0);
    check("ac1 n_acc", 64'(acc_addr.size()), 64'd1);
    pulse_rd_reset();
    check("ac1 cleared", 64'(read_ac_fault), 64'd0);

    // rd_reset during FIRST, done three cycles later: silent drain.
    tlb_lat = 4; prev = read_data;
    acc_addr.delete(); acc_len.delete();
    @(posedge clk); #1 read_address = 32'h00001004; read_length = 4'd4; read_do = 1;
    @(posedge clk); #1 read_do = 0; req_rd_reset = 1;
    @(posedge clk); #1 req_rd_reset = 0;
    @(negedge clk);
    check("abort drain do", 64'(tlbread_do), 64'd1);
    flag = 0;
    repeat (6) begin @(negedge clk); flag |= read_done; end
    check("abort no done", 64'(flag), 64'd0);
    check("abort no fault", 64'({read_page_fault, read_ac_fault}), 64'd0);
    check("abort idle", 64'(tlbread_do), 64'd0);
    check("abort n_acc", 64'(acc_addr.size()), 64'd1);
    check("abort data held", read_data, prev);

    // rd_reset in the same cycle as the final tlbread_done: abort wins.
    tlb_lat = 2; reset_with_done = 1;
    acc_addr.delete(); acc_len.delete();
    @(posedge clk); #1 read_address = 32'h00001000; read_length = 4'd4; read_do = 1;
    @(posedge clk); #1 read_do = 0;
    flag = 0;
    repeat (6) begin @(negedge clk); flag |= read_done; end
    reset_with_done = 0;
    check("same-cycle no done", 64'(flag), 64'd0);
    check("same-cycle n_acc", 64'(acc_addr.size()), 64'd1);
    check("same-cycle idle", 64'(tlbread_do), 64'd0);
    check("same-cycle data held", read_data, prev);
    tlb_lat = 1;
    run_vec(tbl[1], "after abort");

    // SPLIT_EN=0: a line-crossing read is one full-length access.
    @(posedge clk); #1 ns_read_address = 32'h0000100E; ns_read_length = 4'd4; ns_read_do = 1;
    @(negedge clk);
    check("ns do", 64'(ns_tlbread_do), 64'd1);
    check("ns addr", 64'(ns_tlbread_address), 64'h100E);
    check("ns len", 64'(ns_tlbread_length), 64'd4);
    @(posedge clk); #1 ns_tlbread_done = 1; ns_tlbread_data = 64'hEEEEEEEE44332211;
    @(posedge clk); #1 ns_tlbread_done = 0;
    @(negedge clk);
    check("ns done", 64'(ns_read_done), 64'd1);
    check("ns data", ns_read_data, 64'h44332211);
    check("ns no second", 64'(ns_tlbread_do), 64'd0);
    @(posedge clk); #1 ns_read_do = 0;

    // Randomized reads against the byte-array model, with occasional TLB retries.
    for (int k = 0; k < 40; k++) begin
      v.addr = $urandom;
      if (k % 2 == 0) v.addr[31:8] = 24'h000010;
      v.len = 4'($urandom_range(1, 8));
      tlb_lat = $urandom_range(1, 3);
      tlb_retry = ($urandom_range(0, 3) == 0);
      off = int'(v.addr[3:0]);
      v.a0 = v.addr;
      v.a1 = {v.addr[31:4], 4'h0} + 32'd16;
      if (int'(v.len) > 16 - off) begin
        v.n_acc = 2; v.l0 = 4'(16 - off); v.l1 = 4'(int'(v.len) - (16 - off));
      end else begin
        v.n_acc = 1; v.l0 = v.len; v.l1 = 4'd0;
      end
      v.data = '0;
      for (int i = 0; i < int'(v.len); i++) v.data[8*i +: 8] = mem[8'(v.addr + 32'(i))];
      run_vec(v, $sformatf("rnd%0d", k));
    end
    tlb_retry = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
